// File: rtl/softmax_pkg.sv
// Shared constants and FSM encoding for the softmax normaliser divider.
// SOFTMAX_NORM_DIV_ROUND_EN adds a 17th rounding step.
package softmax_pkg;

    localparam int FRAC_W = 16;
    localparam logic [FRAC_W-1:0] U016_SAT = 16'hFFFF;

`ifdef SOFTMAX_NORM_DIV_ROUND_EN
    localparam int DIV_STEPS = FRAC_W + 1;
`else
    localparam int DIV_STEPS = FRAC_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/norm_div_step.sv
// One restoring-division step: shift the remainder left, trial-subtract the
// divisor, and emit the resulting quotient bit.
module norm_div_step #(
    parameter int W = 24
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] den,
    output logic [W:0]   rem_next,
    output logic         q_bit
);

    logic [W:0] rem_sh;
    logic [W:0] den_x;

    // The remainder is always below den < 2^W, so the shift never loses a 1.
    assign rem_sh   = rem << 1;
    assign den_x    = {1'b0, den};
    assign q_bit    = (rem_sh >= den_x);
    assign rem_next = q_bit ? (rem_sh - den_x) : rem_sh;

endmodule

// File: rtl/softmax_norm_div.sv
// Iterative U0.16 divider for softmax normalisation: out = floor(num*2^16/den).
// Define SOFTMAX_NORM_DIV_ROUND_EN for round-half-up via one extra step.
module softmax_norm_div
    import softmax_pkg::*;
#(
    parameter int W = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_num,
    input  logic [W-1:0]  in_den,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_u016,
    output logic          out_dz,
    output logic [1:0]    dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, and
    // DONE holds its outputs stable until out_ready is seen.

    state_t state, state_n;

    logic [W:0]           rem;
    logic [W-1:0]         den_q;
    logic [DIV_STEPS-1:0] quo;
    logic [4:0]           cnt;

    logic [W:0]           rem_next;
    logic                 q_bit;
    logic [DIV_STEPS-1:0] quo_n;
    logic [FRAC_W-1:0]    res;
    logic                 last_step;
    logic                 accept;
    logic                 sat;

    norm_div_step #(.W(W)) u_step (
        .rem      (rem),
        .den      (den_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign quo_n     = {quo[DIV_STEPS-2:0], q_bit};
    assign last_step = (cnt == 5'(DIV_STEPS - 1));
    assign accept    = in_valid && (state == IDLE);
    assign sat       = (in_num >= in_den);

`ifdef SOFTMAX_NORM_DIV_ROUND_EN
    logic [FRAC_W:0] rnd;
    assign rnd = {1'b0, quo_n[FRAC_W:1]} + {{FRAC_W{1'b0}}, quo_n[0]};
    assign res = rnd[FRAC_W] ? U016_SAT : rnd[FRAC_W-1:0];
`else
    assign res = quo_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = sat ? DONE : CALC;
            end
            CALC: begin
                if (last_step) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            den_q    <= '0;
            quo      <= '0;
            cnt      <= '0;
            out_u016 <= '0;
            out_dz   <= 1'b0;
        end else if (accept) begin
            rem   <= {1'b0, in_num};
            den_q <= in_den;
            quo   <= '0;
            cnt   <= '0;
            // num >= den covers den == 0; both saturate, only den == 0 flags.
            if (sat) begin
                out_u016 <= U016_SAT;
                out_dz   <= (in_den == '0);
            end
        end else if (state == CALC) begin
            rem <= rem_next;
            quo <= quo_n;
            cnt <= cnt + 5'd1;
            if (last_step) begin
                out_u016 <= res;
                out_dz   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_softmax_norm_div.sv
// Directed and random bench for softmax_norm_div; honours
// SOFTMAX_NORM_DIV_ROUND_EN for expected latency and rounding.
module tb_softmax_norm_div;

    localparam int W = 24;
`ifdef SOFTMAX_NORM_DIV_ROUND_EN
    localparam int  CALC_LAT = 18;
    localparam bit  ROUND    = 1'b1;
`else
    localparam int  CALC_LAT = 17;
    localparam bit  ROUND    = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_num;
    logic [W-1:0] in_den;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_u016;
    logic         out_dz;
    logic [1:0]   dbg_state;

    int n_vec;
    int n_err;

    softmax_norm_div #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_u016  (out_u016),
        .out_dz    (out_dz),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_q(input longint num, input longint den);
        longint q;
        if (ROUND) q = ((num * 131072) / den + 1) / 2;
        else       q = (num * 65536) / den;
        if (q > 65535) q = 65535;
        return 16'(q);
    endfunction

    // Present a pair, wait for the result, then check it.
    // Edge count includes the acceptance edge.
    task automatic run_op(input string tag, input logic [W-1:0] num, input logic [W-1:0] den,
                          input logic [15:0] exp_q, input logic exp_dz, input int exp_lat,
                          input bit release_now);
        int edges;
        @(negedge clk);
        in_num   = num;
        in_den   = den;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_num   = $urandom_range(0, 2**W - 1);
        in_den   = $urandom_range(0, 2**W - 1);
        edges    = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        chk({tag, "_quot"}, 32'(out_u016), 32'(exp_q));
        chk({tag, "_dz"}, 32'(out_dz), 32'(exp_dz));
        if (release_now) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [W-1:0] rn;
        logic [W-1:0] rd;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(out_u016), 32'd0);
        chk("rst_dz", 32'(out_dz), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("half", 24'd1, 24'd2, 16'h8000, 1'b0, CALC_LAT, 1'b1);
        run_op("two_thirds", 24'd2, 24'd3, ROUND ? 16'hAAAB : 16'hAAAA, 1'b0, CALC_LAT, 1'b1);
        run_op("one_third", 24'd1, 24'd3, 16'h5555, 1'b0, CALC_LAT, 1'b1);
        run_op("div_zero", 24'd7, 24'd0, 16'hFFFF, 1'b1, 1, 1'b1);
        run_op("equal", 24'd5, 24'd5, 16'hFFFF, 1'b0, 1, 1'b1);
        run_op("num_gt_den", 24'hFFFFFF, 24'd1, 16'hFFFF, 1'b0, 1, 1'b1);
        run_op("zero_num", 24'd0, 24'd9, 16'h0000, 1'b0, CALC_LAT, 1'b1);
        run_op("near_one", 24'hFFFFFE, 24'hFFFFFF, ROUND ? 16'hFFFF : 16'hFFFF, 1'b0, CALC_LAT, 1'b1);

        // Output hold with back-pressure; in_valid is asserted meanwhile and must be ignored.
        run_op("hold", 24'd1, 24'd2, 16'h8000, 1'b0, CALC_LAT, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_num   = 24'd3;
            in_den   = 24'd4;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_quot", 32'(out_u016), 32'h8000);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hold_release_idle", 32'(in_ready), 32'd1);
        chk("hold_release_valid", 32'(out_valid), 32'd0);

        // Reset asserted mid-CALC after step 8.
        @(negedge clk);
        in_num   = 24'd1;
        in_den   = 24'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quot", 32'(out_u016), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 24'd2, 24'd3, ROUND ? 16'hAAAB : 16'hAAAA, 1'b0, CALC_LAT, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            rd = $urandom_range(1, 2**W - 1);
            rn = $urandom_range(0, int'(rd) - 1);
            run_op("random", rn, rd, ref_q(longint'(rn), longint'(rd)), 1'b0, CALC_LAT, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
